// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory responder with wait states and fault reporting
//
// Purpose: accepts CPU load/store requests over a valid/ready handshake, performs
// RISC-V byte/half/word accesses on a word-organised array after WAIT_STATES
// cycles, and returns the result on a valid/ready response channel.
//
// Ports:
//   iCLK        clock, rising edge
//   iRST        asynchronous active-low reset
//   iReqValid   request present
//   oReqReady   high only in IDLE
//   iWrite      1 = store, 0 = load
//   iAddr       byte address
//   iFunct3     RISC-V load/store funct3
//   iWData      store data, right-aligned
//   oRespValid  response present
//   iRespReady  requester takes response
//   oRData      extended load result, 0 for stores and faults
//   oErr        access fault, meaningful while oRespValid=1
module data_mem_responder #(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter int          WAIT_STATES  = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iWData,
  output logic        oRespValid,
  input  logic        iRespReady,
  output logic [31:0] oRData,
  output logic        oErr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // The access is evaluated either on the live inputs (zero-wait or fault at the
  // accept edge) or on the latched request (last WAIT edge).
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [2:0]            cur_funct3;
  logic [31:0]           cur_wdata;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  acc_err;
  logic [3:0]            byte_en;
  logic [31:0]           wlane;
  logic [31:0]           rword;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_data;
  logic                  accept;
  logic                  last_wait;
  logic                  access;
  logic                  mem_we;

  always_comb begin
    cur_write  = (state_q == ST_IDLE) ? iWrite  : write_q;
    cur_addr   = (state_q == ST_IDLE) ? iAddr   : addr_q;
    cur_funct3 = (state_q == ST_IDLE) ? iFunct3 : funct3_q;
    cur_wdata  = (state_q == ST_IDLE) ? iWData  : wdata_q;

    // Unsigned wrap makes addresses below the base land far out of range.
    offset   = cur_addr - BASE_ADDRESS;
    in_range = ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    word_idx = offset[ADDR_WIDTH+1:2];

    if (cur_write) begin
      funct3_ok = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
    end else begin
      funct3_ok = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010) ||
                  (cur_funct3 == 3'b100) || (cur_funct3 == 3'b101);
    end

    // funct3[1:0] carries the access size for both loads and stores.
    case (cur_funct3[1:0])
      2'b01:   misaligned = cur_addr[0];
      2'b10:   misaligned = (cur_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    acc_err = !in_range || !funct3_ok || misaligned;

    case (cur_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << cur_addr[1:0];
        wlane   = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlane   = cur_wdata;
      end
    endcase

    rword    = mem[word_idx];
    sel_byte = 8'(rword >> {cur_addr[1:0], 3'b000});
    sel_half = cur_addr[1] ? rword[31:16] : rword[15:0];

    case (cur_funct3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = rword;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase

    accept    = iReqValid && (state_q == ST_IDLE);
    last_wait = (state_q == ST_WAIT) && (cnt_q <= 4'd1);
    access    = (accept && !acc_err && (WAIT_STATES == 0)) || last_wait;
    // No commit while reset is held, so an abandoned store never lands.
    mem_we    = access && cur_write && iRST;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (iReqValid) begin
          write_d  = iWrite;
          addr_d   = iAddr;
          funct3_d = iFunct3;
          wdata_d  = iWData;
          if (acc_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = 32'd0;
            err_d        = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = cur_write ? 32'd0 : load_data;
            err_d        = 1'b0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (last_wait) begin
          cnt_d        = 4'd0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = cur_write ? 32'd0 : load_data;
          err_d        = 1'b0;
        end
      end
      ST_RESP: begin
        if (iRespReady) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = 32'd0;
          err_d        = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        rdata_d      = 32'd0;
        err_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      funct3_q     <= 3'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  assign oReqReady  = (state_q == ST_IDLE);
  assign oRespValid = resp_valid_q;
  assign oRData     = rdata_q;
  assign oErr       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder at WAIT_STATES 1, 3 and 0
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int WS [3] = '{1, 3, 0};

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        wr         [3];
  logic [31:0] addr       [3];
  logic [2:0]  f3         [3];
  logic [31:0] wdata      [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] rdata      [3];
  logic        err        [3];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Reference byte image of the first 64 bytes of each instance's array.
  bit [7:0] ref_mem [3][64];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDRESS(BASE), .WAIT_STATES(1)) u_ws1 (
    .iCLK(clk), .iRST(rst_n[0]), .iReqValid(req_valid[0]), .oReqReady(req_ready[0]),
    .iWrite(wr[0]), .iAddr(addr[0]), .iFunct3(f3[0]), .iWData(wdata[0]),
    .oRespValid(resp_valid[0]), .iRespReady(resp_ready[0]), .oRData(rdata[0]), .oErr(err[0]));

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDRESS(BASE), .WAIT_STATES(3)) u_ws3 (
    .iCLK(clk), .iRST(rst_n[1]), .iReqValid(req_valid[1]), .oReqReady(req_ready[1]),
    .iWrite(wr[1]), .iAddr(addr[1]), .iFunct3(f3[1]), .iWData(wdata[1]),
    .oRespValid(resp_valid[1]), .iRespReady(resp_ready[1]), .oRData(rdata[1]), .oErr(err[1]));

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDRESS(BASE), .WAIT_STATES(0)) u_ws0 (
    .iCLK(clk), .iRST(rst_n[2]), .iReqValid(req_valid[2]), .oReqReady(req_ready[2]),
    .iWrite(wr[2]), .iAddr(addr[2]), .iFunct3(f3[2]), .iWData(wdata[2]),
    .oRespValid(resp_valid[2]), .iRespReady(resp_ready[2]), .oRData(rdata[2]), .oErr(err[2]));

  // Behavioural model: access size/sign from funct3, fault rules, little-endian lanes.
  task automatic model(input int i, input bit w, input logic [31:0] a, input logic [2:0] fn,
                       input logic [31:0] wd, output bit e, output logic [31:0] r);
    logic [31:0] off;
    int size;
    bit sgn;
    bit legal;
    off = a - BASE;
    size = 4; sgn = 0; legal = 1; r = 32'd0;
    if (w) begin
      case (fn)
        3'b000: size = 1;
        3'b001: size = 2;
        3'b010: size = 4;
        default: legal = 0;
      endcase
    end else begin
      case (fn)
        3'b000: begin size = 1; sgn = 1; end
        3'b001: begin size = 2; sgn = 1; end
        3'b010: size = 4;
        3'b100: size = 1;
        3'b101: size = 2;
        default: legal = 0;
      endcase
    end
    e = !legal || (off >= 32'd4096) || ((a % size) != 0);
    if (e) return;
    if (off >= 32'd64) begin
      $display("FAIL model_range inst%0d: offset %h outside modelled window 00000040", i, off);
      $fatal(1);
    end
    for (int k = 0; k < size; k++) begin
      if (w) ref_mem[i][int'(off) + k] = wd[8*k +: 8];
      else   r[8*k +: 8] = ref_mem[i][int'(off) + k];
    end
    if (!w && sgn) begin
      for (int j = 8*size; j < 32; j++) r[j] = r[8*size-1];
    end
  endtask

  task automatic do_txn(input int i, input bit w, input logic [31:0] a, input logic [2:0] fn,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd);
    bit e;
    logic [31:0] er;
    int lat, exp_lat;
    model(i, w, a, fn, wd, e, er);
    exp_lat = e ? 0 : WS[i];
    @(negedge clk);
    req_valid[i] = 1'b1; wr[i] = w; addr[i] = a; f3[i] = fn; wdata[i] = wd; resp_ready[i] = 1'b0;
    vectors++;
    if (req_ready[i] !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle inst%0d: got %b expected 1", i, req_ready[i]);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    while (resp_valid[i] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency inst%0d addr %h f3 %0d: got %0d expected %0d", i, a, fn, lat, exp_lat);
    end
    repeat (hold) @(posedge clk);
    #1;
    vectors++;
    if (rdata[i] !== er) begin
      errors++; $display("FAIL rdata inst%0d w%0b addr %h f3 %0d: got %h expected %h", i, w, a, fn, rdata[i], er);
    end
    vectors++;
    if (err[i] !== e) begin
      errors++; $display("FAIL err inst%0d w%0b addr %h f3 %0d: got %b expected %b", i, w, a, fn, err[i], e);
    end
    rd = rdata[i];
    @(negedge clk); resp_ready[i] = 1'b1;
    @(posedge clk); #1; resp_ready[i] = 1'b0;
    vectors++;
    if (resp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
      errors++; $display("FAIL handshake inst%0d: got valid %b ready %b expected valid 0 ready 1", i, resp_valid[i], req_ready[i]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; resp_ready[i] = 1'b0;
      wr[i] = 1'b0; addr[i] = 32'd0; f3[i] = 3'd0; wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (resp_valid[i] !== 1'b0 || rdata[i] !== 32'd0 || err[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst%0d: got valid %b rdata %h err %b ready %b expected 0 0 0 1",
                 i, resp_valid[i], rdata[i], err[i], req_ready[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    do_txn(0, 1, BASE + 4, 3'b010, 32'hDEAD_BEEF, 0, rd);
    vectors++;
    if (rd !== 32'd0) begin errors++; $display("FAIL sw_rdata: got %h expected 00000000", rd); end
    do_txn(0, 0, BASE + 4, 3'b010, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_first: got %h expected deadbeef", rd); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd;
    do_txn(0, 1, BASE + 5, 3'b000, 32'h0000_0080, 0, rd);
    do_txn(0, 0, BASE + 5, 3'b000, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h expected ffffff80", rd); end
    do_txn(0, 0, BASE + 5, 3'b100, 32'd0, 1, rd);
    vectors++;
    if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h expected 00000080", rd); end
    do_txn(0, 0, BASE + 4, 3'b010, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'hDEAD_80EF) begin errors++; $display("FAIL lw_after_sb: got %h expected dead80ef", rd); end
    do_txn(0, 1, BASE + 6, 3'b001, 32'h0000_1234, 0, rd);
    do_txn(0, 0, BASE + 4, 3'b010, 32'd0, 2, rd);
    vectors++;
    if (rd !== 32'h1234_80EF) begin errors++; $display("FAIL lw_after_sh: got %h expected 123480ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    do_txn(0, 0, BASE + 3, 3'b001, 32'd0, 0, rd);
    do_txn(0, 1, BASE + 32'h1000, 3'b010, 32'hFFFF_FFFF, 0, rd);
    do_txn(0, 1, BASE + 4, 3'b100, 32'hFFFF_FFFF, 0, rd);
    do_txn(0, 0, BASE + 4, 3'b010, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'h1234_80EF) begin errors++; $display("FAIL lw_after_errors: got %h expected 123480ef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    bit e;
    logic [31:0] er;
    int lat;
    do_txn(0, 1, BASE + 8, 3'b010, 32'h0BAD_F00D, 0, rd);
    model(0, 0, BASE + 4, 3'b010, 32'd0, e, er);
    @(negedge clk);
    req_valid[0] = 1'b1; wr[0] = 1'b0; addr[0] = BASE + 4; f3[0] = 3'b010; resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (resp_valid[0] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", lat); end
    // Keep presenting a store that must not be taken while the response is stalled.
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = BASE + 8; f3[0] = 3'b010; wdata[0] = 32'h5555_5555;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (resp_valid[0] !== 1'b1 || rdata[0] !== er || err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid %b rdata %h err %b ready %b expected 1 %h 0 0",
                 c, resp_valid[0], rdata[0], err[0], req_ready[0], er);
      end
    end
    @(negedge clk); req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    @(posedge clk); #1; resp_ready[0] = 1'b0;
    vectors++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid %b ready %b expected 0 1", resp_valid[0], req_ready[0]);
    end
    do_txn(0, 0, BASE + 8, 3'b010, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL bp_no_store: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    do_txn(1, 1, BASE + 8, 3'b010, 32'h1111_1111, 0, rd);
    @(negedge clk);
    req_valid[1] = 1'b1; wr[1] = 1'b1; addr[1] = BASE + 8; f3[1] = 3'b010; wdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n[1] = 1'b0;
    #1;
    vectors++;
    if (resp_valid[1] !== 1'b0 || rdata[1] !== 32'd0 || err[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: got valid %b rdata %h err %b ready %b expected 0 0 0 1",
               resp_valid[1], rdata[1], err[1], req_ready[1]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n[1] = 1'b1;
    do_txn(1, 0, BASE + 8, 3'b010, 32'd0, 0, rd);
    vectors++;
    if (rd !== 32'h1111_1111) begin errors++; $display("FAIL reset_uncommitted: got %h expected 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] vals [4];
    bit e;
    logic [31:0] er;
    int prev;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      vals[k] = $urandom;
      do_txn(2, 1, BASE + 16 + 4*k, 3'b010, vals[k], 0, rd);
    end
    @(negedge clk);
    req_valid[2] = 1'b1; resp_ready[2] = 1'b1; wr[2] = 1'b0; f3[2] = 3'b010; addr[2] = BASE + 16;
    for (int k = 0; k < 4; k++) begin
      model(2, 0, BASE + 16 + 4*k, 3'b010, 32'd0, e, er);
      @(posedge clk); #1;
      vectors++;
      if (resp_valid[2] !== 1'b1 || rdata[2] !== vals[k] || rdata[2] !== er || err[2] !== 1'b0) begin
        errors++;
        $display("FAIL stream %0d: got valid %b rdata %h err %b expected 1 %h 0", k, resp_valid[2], rdata[2], err[2], vals[k]);
      end
      if (k > 0) begin
        vectors++;
        if (cyc - prev != 2) begin errors++; $display("FAIL stream_spacing %0d: got %0d expected 2", k, cyc - prev); end
      end
      prev = cyc;
      if (k < 3) addr[2] = BASE + 16 + 4*(k+1);
      else req_valid[2] = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
        errors++; $display("FAIL stream_handshake %0d: got ready %b valid %b expected 1 0", k, req_ready[2], resp_valid[2]);
      end
    end
    resp_ready[2] = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) do_txn(i, 1, BASE + 4*w, 3'b010, $urandom, 0, rd);
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 7);
        if (sel == 0)      a = BASE + 32'h1000 + $urandom_range(0, 255);
        else if (sel == 1) a = BASE - 32'd1 - $urandom_range(0, 255);
        else               a = BASE + $urandom_range(0, 63);
        do_txn(i, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2), rd);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port. It accepts load/store requests over a valid/ready handshake and holds a word-organised data array.
- Performs RISC-V byte/half/word access with sign or zero extension, and adds a configurable number of wait states.
- Returns each result over a second valid/ready response channel.
- Flags misaligned, out-of-range or illegal-funct3 accesses as errors. Errored accesses have no memory side effect.

Parameters:
ADDR_WIDTH, 10, word-index bits; array depth = 2^ADDR_WIDTH words (4 KiB default)
BASE_ADDRESS, 32'h1001_0000, byte address of word 0
WAIT_STATES, 1, cycles spent in WAIT before access (0 allowed, max 15)

Ports:
iCLK  input  1  clock; all state updates on rising edge
iRST  input  1  reset, asynchronous, active-low
iReqValid  input  1  request present
oReqReady  output  1  responder can accept; equals (state==IDLE)
iWrite  input  1  1=store, 0=load
iAddr  input  32  byte address
iFunct3  input  3  RISC-V funct3 of the load/store
iWData  input  32  store data, right-aligned
oRespValid  output  1  response present
iRespReady  input  1  requester takes response
oRData  output  32  load result, extended; 0 for stores and errors
oErr  output  1  access fault, valid while oRespValid=1

Behaviour:
- Reset (iRST=0, async): state=IDLE, oRespValid=0, oRData=0, oErr=0, wait counter=0, request latches cleared. Array contents are not reset.
- Reset mid-operation abandons the request. A store not yet committed stays uncommitted.
- FSM: IDLE, WAIT, RESP.
- Accept edge: rising edge with iReqValid=1 and oReqReady=1. At this edge iWrite, iAddr, iFunct3 and iWData are latched.
- Offset = iAddr - BASE_ADDRESS (32-bit unsigned). Word index = offset[ADDR_WIDTH+1:2].
- Error if any of the following:
  - offset >= 4*2^ADDR_WIDTH
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - store funct3 not in {000, 001, 010}
  - load funct3 not in {000, 001, 010, 100, 101}
- On error: IDLE->RESP at the accept edge. oErr=1, oRData=0, no array access.
- No error, WAIT_STATES=0: IDLE->RESP at the accept edge; access performed at that edge.
- No error, WAIT_STATES>0: IDLE->WAIT with counter=WAIT_STATES.
  - Each WAIT edge decrements the counter.
  - The edge at which the counter reaches 0 performs the access and moves to RESP.
- Latency: oRespValid rises WAIT_STATES edges after the accept edge (0 for errors).
- Store lanes:
  - sb (000) writes iWData[7:0] to byte addr[1:0].
  - sh (001) writes iWData[15:0] to half addr[1].
  - sw (010) writes all 32 bits.
  - Other bytes of the word are untouched. oRData=0.
- Load extension:
  - lb (000) and lh (001) sign-extend.
  - lbu (100) and lhu (101) zero-extend.
  - lw (010) returns the word as-is.
  - Lane selection is by addr[1:0] / addr[1].
- RESP: oRespValid=1 with oRData and oErr stable until the edge with iRespReady=1. That edge returns to IDLE and clears oRespValid.
- oReqReady=0 during WAIT and RESP; requests in those states are ignored, not queued.
- A new request can be accepted one cycle after the response handshake, so peak throughput is 1 request per WAIT_STATES+2 cycles.

Test Plan:
1. WAIT_STATES=1, sw 0xDEADBEEF @0x1001_0004, then lw @0x1001_0004 -> each oRespValid exactly 1 edge after accept; store oRData=0, oErr=0; load oRData=0xDEADBEEF.
2. sb iWData=0x0000_0080 @0x1001_0005 ->
   - lb @0x1001_0005 returns 0xFFFF_FF80.
   - lbu @0x1001_0005 returns 0x0000_0080.
   - lw @0x1001_0004 returns 0xDEAD_80EF.
   - sh 0x1234 @0x1001_0006 then lw @0x1001_0004 returns 0x1234_80EF.
3. Errors -> oRespValid at the accept edge with oErr=1 and oRData=0, and a following lw @0x1001_0004 unchanged:
   - lh @0x1001_0003
   - sw @0x1001_1000 (out of range)
   - store with funct3=100
4. Backpressure: complete a lw, hold iRespReady=0 for 5 cycles while iReqValid=1 -> oRespValid, oRData and oErr stable, oReqReady=0, no second access. Release -> IDLE next edge, oReqReady=1.
5. WAIT_STATES=3: issue sw 0xCAFEF00D @0x1001_0008 over old value 0x1111_1111, drive iRST=0 on the second WAIT cycle -> outputs 0 immediately, state IDLE; after release, lw @0x1001_0008 returns 0x1111_1111.
6. WAIT_STATES=0: stream 4 lw with iRespReady=1 -> each response at its accept edge, one accept every 2 cycles, data matches prior stores.
